dmem_responder: RTL

//  Data-memory responder for the pipeline MEMORY stage, the far end of its load/store traffic.

---
 rtl/dmem_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Word-indexed data-memory responder: one request in flight, fixed service latency,
// response held until the requester takes it; out-of-range words are flagged, never aliased.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] DEPTH_W  = 64'(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        we_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;

  logic [63:0] mem [DEPTH];

  logic          in_range_d;
  logic          commit_d;
  logic          mem_we_d;
  logic [AW-1:0] idx_d;

  // Full-width compare so that an index beyond DEPTH can never fold onto a legal word.
  assign in_range_d = (addr_q < DEPTH_W);
  assign idx_d      = addr_q[AW-1:0];
  assign commit_d   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we_d   = commit_d && we_q && in_range_d && rst_n;

  // Request capture: data only, loaded on the accept edge.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage: contents survive reset, written only on an in-range write commit.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem[idx_d] <= wdata_q;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !in_range_d;
            rsp_rdata_q <= (in_range_d && !we_q) ? mem[idx_d] : 64'd0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 64'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
